// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_fifo
// Description : Commit-trace capture FIFO for the single-cycle mips core.
//               Every qualified architectural write (GRF write-back to a
//               non-zero register, DM store) becomes a {kind, pc, addr, data}
//               record in a circular buffer. Records drain over a show-ahead
//               valid/ready port. The core is never stalled: records that do
//               not fit are dropped, counted (saturating) and flagged sticky.
//
// Ports       : clk          - rising-edge clock
//               reset        - synchronous active-high reset, clears all state
//               grf_we/addr/wdata - GRF write-back observed this cycle
//               dm_we/addr/wdata  - DM store observed this cycle
//               pc           - PC of the instruction committing this cycle
//               trace_valid  - head record available (count != 0)
//               trace_ready  - consumer accepts head record
//               trace_kind   - 0 = GRF record, 1 = DM record
//               trace_pc/addr/data - head record fields
//               count        - occupancy, 0..DEPTH
//               overflow     - sticky, set on first dropped record
//               drop_cnt     - dropped records, saturating at 16'hFFFF
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_fifo #(
    parameter int DEPTH = 16,   // power of two, >= 4
    parameter int AW    = 4     // log2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          grf_we,
    input  logic [4:0]    grf_addr,
    input  logic [31:0]   grf_wdata,
    input  logic          dm_we,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic [31:0]   pc,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic          trace_kind,
    output logic [31:0]   trace_pc,
    output logic [31:0]   trace_addr,
    output logic [31:0]   trace_data,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_two     = (AW+1)'(2);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    // Storage, split per field
    logic          r_kind [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;

    logic          w_grf_ev;
    logic          w_dm_ev;
    logic [AW:0]   w_free;
    logic          w_grf_push;
    logic          w_dm_push;
    logic [AW-1:0] w_dm_idx;
    logic [AW:0]   w_push_n;
    logic [1:0]    w_drop_n;
    logic [16:0]   w_drop_sum;
    logic [15:0]   w_drop_next;
    logic          w_pop;
    logic [AW:0]   w_count_next;

    // Event qualification: writes to $0 are architecturally invisible
    assign w_grf_ev = grf_we && (grf_addr != 5'd0);
    assign w_dm_ev  = dm_we;

    // Admission uses the occupancy at the start of the cycle; a pop in the
    // same cycle does not free space for this cycle's pushes. GRF has
    // priority over DM when only one slot is left.
    assign w_free     = c_depth - r_count;
    assign w_grf_push = w_grf_ev && (w_free != '0);
    assign w_dm_push  = w_dm_ev && (w_grf_ev ? (w_free >= c_two) : (w_free != '0));

    // DM record lands right after the GRF record when both are admitted
    assign w_dm_idx = w_grf_push ? (r_wp + c_ptr_one) : r_wp;

    assign w_push_n = {{AW{1'b0}}, w_grf_push} + {{AW{1'b0}}, w_dm_push};
    assign w_drop_n = {1'b0, w_grf_ev & ~w_grf_push} + {1'b0, w_dm_ev & ~w_dm_push};

    // Saturating drop counter
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_drop_n};
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    assign w_pop        = (r_count != '0) && trace_ready;
    assign w_count_next = r_count + w_push_n - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            // Zeroed so the head outputs are defined while the FIFO is empty
            for (int i = 0; i < DEPTH; i++) begin
                r_kind[i] <= 1'b0;
                r_pc[i]   <= '0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_grf_push) begin
                r_kind[r_wp] <= 1'b0;
                r_pc[r_wp]   <= pc;
                r_addr[r_wp] <= {27'd0, grf_addr};
                r_data[r_wp] <= grf_wdata;
            end
            if (w_dm_push) begin
                r_kind[w_dm_idx] <= 1'b1;
                r_pc[w_dm_idx]   <= pc;
                r_addr[w_dm_idx] <= dm_addr;
                r_data[w_dm_idx] <= dm_wdata;
            end
            r_wp <= r_wp + w_push_n[AW-1:0];
            if (w_pop) begin
                r_rp <= r_rp + c_ptr_one;
            end
            r_count    <= w_count_next;
            r_drop_cnt <= w_drop_next;
            if (w_drop_n != 2'd0) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Show-ahead head
    assign trace_valid = (r_count != '0);
    assign trace_kind  = r_kind[r_rp];
    assign trace_pc    = r_pc[r_rp];
    assign trace_addr  = r_addr[r_rp];
    assign trace_data  = r_data[r_rp];

    assign count    = r_count;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trace_fifo
// Description : Self-checking bench for wb_trace_fifo. Directed scenarios
//               followed by a random phase, all compared every cycle against
//               a queue-based reference model of the trace FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          grf_we;
    logic [4:0]    grf_addr;
    logic [31:0]   grf_wdata;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   pc;
    logic          trace_valid;
    logic          trace_ready;
    logic          trace_kind;
    logic [31:0]   trace_pc;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    rec_t q[$];
    int   m_drop;
    bit   m_ovf;
    bit   m_was_reset;

    wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .grf_we     (grf_we),
        .grf_addr   (grf_addr),
        .grf_wdata  (grf_wdata),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .pc         (pc),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_kind (trace_kind),
        .trace_pc   (trace_pc),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, evaluated on the inputs currently driven
    task automatic model_step();
        rec_t ev[$];
        int   free;
        int   take;
        bit   do_pop;
        if (reset) begin
            q.delete();
            m_drop      = 0;
            m_ovf       = 1'b0;
            m_was_reset = 1'b1;
        end else begin
            m_was_reset = 1'b0;
            if (grf_we && grf_addr != 5'd0)
                ev.push_back('{kind: 1'b0, pc: pc, addr: {27'd0, grf_addr}, data: grf_wdata});
            if (dm_we)
                ev.push_back('{kind: 1'b1, pc: pc, addr: dm_addr, data: dm_wdata});
            free   = DEPTH - q.size();
            take   = (ev.size() < free) ? ev.size() : free;
            do_pop = (q.size() != 0) && trace_ready;
            if (ev.size() > take) begin
                m_ovf  = 1'b1;
                m_drop = m_drop + (ev.size() - take);
                if (m_drop > 16'hFFFF) m_drop = 16'hFFFF;
            end
            if (do_pop) void'(q.pop_front());
            for (int k = 0; k < take; k++) q.push_back(ev[k]);
        end
    endtask

    task automatic compare();
        chk("count", 32'(count), 32'(q.size()));
        chk("valid", 32'(trace_valid), 32'(q.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() != 0) begin
            chk("head_kind", 32'(trace_kind), 32'(q[0].kind));
            chk("head_pc", trace_pc, q[0].pc);
            chk("head_addr", trace_addr, q[0].addr);
            chk("head_data", trace_data, q[0].data);
        end else if (m_was_reset) begin
            chk("rst_kind", 32'(trace_kind), 32'd0);
            chk("rst_pc", trace_pc, 32'd0);
            chk("rst_addr", trace_addr, 32'd0);
            chk("rst_data", trace_data, 32'd0);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        reset = 1'b0; grf_we = 1'b0; dm_we = 1'b0;
        grf_addr = '0; grf_wdata = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic set_grf(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        grf_we = 1'b1; grf_addr = a; grf_wdata = d; pc = p;
    endtask

    task automatic set_dm(input logic [31:0] a, input logic [31:0] d);
        dm_we = 1'b1; dm_addr = a; dm_wdata = d;
    endtask

    initial begin
        m_drop = 0; m_ovf = 1'b0; m_was_reset = 1'b0;
        idle(); pc = '0; trace_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        cycle(); cycle();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(trace_valid), 32'd0);
        reset = 1'b0;

        // Single GRF write
        set_grf(5'd8, 32'h1234, 32'h3000);
        cycle();
        idle();
        chk("single_valid", 32'(trace_valid), 32'd1);
        chk("single_kind", 32'(trace_kind), 32'd0);
        chk("single_addr", trace_addr, 32'd8);
        chk("single_data", trace_data, 32'h1234);
        chk("single_pc", trace_pc, 32'h3000);
        chk("single_count", 32'(count), 32'd1);
        cycle();    // still held, ready low
        trace_ready = 1'b1;
        cycle();
        chk("single_pop", 32'(count), 32'd0);

        // $0 filter
        for (int i = 0; i < 5; i++) begin
            set_grf(5'd0, 32'hDEAD0000 + i, 32'h3100 + 4 * i);
            cycle();
        end
        idle();
        chk("zero_count", 32'(count), 32'd0);
        chk("zero_drop", 32'(drop_cnt), 32'd0);

        // Dual event on empty FIFO
        trace_ready = 1'b0;
        set_grf(5'd9, 32'h99, 32'h3200);
        set_dm(32'h10, 32'h55);
        cycle();
        idle();
        chk("dual_count", 32'(count), 32'd2);
        chk("dual_first_kind", 32'(trace_kind), 32'd0);
        trace_ready = 1'b1;
        cycle();
        chk("dual_second_kind", 32'(trace_kind), 32'd1);
        chk("dual_second_addr", trace_addr, 32'h10);
        cycle();
        chk("dual_empty", 32'(count), 32'd0);

        // Fill and overflow
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_grf(5'(1 + i % 31), 32'hA000 + i, 32'h4000 + 4 * i);
            cycle();
        end
        chk("fill_count", 32'(count), 32'd16);
        set_grf(5'd3, 32'hBAD, 32'h5000);
        cycle();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop1", 32'(drop_cnt), 32'd1);
        set_grf(5'd4, 32'hBAD1, 32'h5004);
        set_dm(32'h20, 32'hBAD2);
        cycle();
        idle();
        chk("ovf_drop3", 32'(drop_cnt), 32'd3);
        trace_ready = 1'b1;
        set_grf(5'd5, 32'hBAD3, 32'h5008);
        cycle();
        idle();
        chk("ovf_drop4", 32'(drop_cnt), 32'd4);
        chk("ovf_count15", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) cycle();
        chk("drain_count", 32'(count), 32'd0);

        // Wrap and stream
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            set_grf(5'd7, 32'hC000 + i, 32'h6000 + 4 * i);
            cycle();
            chk("stream_pc", trace_pc, 32'h6000 + 4 * i);
            chk("stream_le1", 32'(count <= 1), 32'd1);
        end
        idle();
        cycle();
        chk("stream_drop", 32'(drop_cnt), 32'd0);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            idle();
            reset       = ($urandom_range(0, 99) == 0);
            trace_ready = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 60)
                set_grf(5'($urandom_range(0, 31)), $urandom, $urandom);
            else
                pc = $urandom;
            if ($urandom_range(0, 99) < 25)
                set_dm($urandom, $urandom);
            cycle();
        end

        // Reset mid-stream
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_grf(5'd2, 32'hE000 + i, 32'h7000 + 4 * i);
            cycle();
        end
        chk("mid_count5", 32'(count), 32'd5);
        set_grf(5'd6, 32'hF00D, 32'h7100);
        trace_ready = 1'b1;
        reset = 1'b1;
        cycle();
        idle();
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(trace_valid), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        chk("mid_drop", 32'(drop_cnt), 32'd0);
        chk("mid_pc", trace_pc, 32'd0);
        chk("mid_data", trace_data, 32'd0);
        trace_ready = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Hardware commit-trace capture for the single-cycle `mips` core. Observes every architectural write the core performs (GRF write-back and DM store) and queues each as a trace record in an internal FIFO. Records are drained over a valid/ready interface by a downstream consumer, either a UART dumper or a bench checker. The block is the reader counterpart to the core's write side: it does not stall the core, so records that do not fit are dropped and counted.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 4.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `grf_we`  in  1  core writes the GRF this cycle.
- `grf_addr`  in  5  GRF destination register.
- `grf_wdata`  in  32  GRF write data.
- `dm_we`  in  1  core writes DM this cycle.
- `dm_addr`  in  32  DM byte address.
- `dm_wdata`  in  32  DM write data.
- `pc`  in  32  PC of the instruction committing this cycle.
- `trace_valid`  out  1  head record available.
- `trace_ready`  in  1  consumer accepts the head record.
- `trace_kind`  out  1  0 = GRF record, 1 = DM record.
- `trace_pc`  out  32  PC of the head record.
- `trace_addr`  out  32  GRF index zero-extended, or DM address.
- `trace_data`  out  32  write data of the head record.
- `count`  out  AW+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky; set on the first dropped record.
- `drop_cnt`  out  16  dropped records, saturating at 16'hFFFF.

## Operation
- Event qualification:
  - GRF event = `grf_we && grf_addr != 0`. Writes to $0 are never recorded.
  - DM event = `dm_we`.
- Storage: circular buffer of {kind, pc, addr, data} with write pointer `wp` and read pointer `rp`, both AW bits and wrapping modulo `DEPTH`. Occupancy is held in a separate counter.
- Push order when both events occur in one cycle: GRF record at `wp`, then DM record at `wp+1`.
- Admission:
  - `free = DEPTH - count`, taken at the start of the cycle.
  - A pop in the same cycle does NOT create room for that cycle's pushes.
  - With 2 events and `free >= 2`, both are pushed.
  - With 2 events and `free == 1`, the GRF record is pushed and the DM record is dropped.
  - With `free == 0`, all events are dropped.
- Drop accounting:
  - `drop_cnt` increments by the number of records dropped that cycle (0, 1 or 2), saturating.
  - `overflow` sets whenever the drop count for a cycle is nonzero. It clears only on `reset`.
- Pop: occurs when `trace_valid && trace_ready` at the rising edge. `rp` advances by 1.
- Count update: `count_next = count + pushes - pop`. Simultaneous push and pop are legal at any non-full occupancy.
- Head outputs: `trace_*` are driven from the entry at `rp` (show-ahead).
  - `trace_valid = (count != 0)`.
  - When `trace_valid` = 0, the `trace_*` values are don't-care, but they must not be X after reset; the storage array is zero-initialised on reset.
- Reset, synchronous:
  - `wp`, `rp`, `count`, `drop_cnt`, `overflow` and the storage array go to 0.
  - `trace_valid` = 0 and `trace_kind/pc/addr/data` = 0 from the first edge with `reset` high.
  - A reset asserted mid-stream discards all queued records. Any push or pop in that cycle is ignored.

## Timing
- Capture latency: an event sampled at edge N makes the record visible on `trace_*`, with `trace_valid` high, after edge N if the FIFO was empty. This is 1 cycle.
- Consumer holding rules:
  - The consumer may hold `trace_ready` low indefinitely.
  - The head record is stable while `trace_valid && !trace_ready`.
- Throughput:
  - 1 pop per cycle maximum.
  - 2 pushes per cycle maximum, which only happens when GRF and DM events coincide; a normal single-cycle core never produces this.
- `count`, `overflow` and `drop_cnt` are registered and update on the same edge as the push or pop that changes them.
- Wrap-around: the pointers roll over from `DEPTH-1` to 0 with no bubble.

## Test plan
- Reset then a single GRF write: `grf_we=1, grf_addr=8, grf_wdata=32'h1234, pc=32'h3000`, with `trace_ready=0`.
  - Expect `trace_valid=1`, `kind=0`, `addr=8`, `data=32'h1234`, `pc=32'h3000`, `count=1` after one edge.
  - Raise `trace_ready`: expect `count=0`.
- $0 filter: `grf_we=1, grf_addr=0` for 5 cycles -> `count` stays 0, `drop_cnt=0`.
- Dual event on an empty FIFO: GRF $9 and DM addr 32'h10 in the same cycle.
  - Expect `count=2`.
  - First pop returns `kind=0`, second pop returns `kind=1` with `addr=32'h10`.
- Fill and overflow, `DEPTH=16`, `trace_ready=0`:
  - Push 16 GRF events: `count=16`.
  - 17th event: dropped, `overflow=1`, `drop_cnt=1`.
  - Dual event while full: `drop_cnt=3`.
  - Pop once while pushing in the same cycle: the push is dropped (`drop_cnt=4`) and `count=15`.
- Wrap and stream: push 40 sequential GRF records with `trace_ready=1` every cycle.
  - All 40 are received in order with matching pc/data.
  - `count` never exceeds 1 and `drop_cnt=0`.
- Reset mid-stream: with `count=5`, assert `reset` for one cycle together with a GRF event and `trace_ready=1`.
  - Expect `count=0`, `trace_valid=0`, `overflow=0`, `drop_cnt=0` and `trace_*=0` afterwards.
